// File: rtl/mem_burst_arbiter.sv
// -----------------------------------------------------------------------------
// mem_burst_arbiter
//
// Lets the I-side and D-side cache fill engines share one 16-bit,
// byte-addressed memory port. The memory reads combinationally and writes on
// the rising clock edge. Each grant is a fixed burst of BLOCK_WORDS
// consecutive words inside one aligned block. Arbitration is round-robin,
// and a running burst is never preempted.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   i_req / i_addr           I-side read-burst request and block address
//   i_grant/i_rvalid/i_rdata/i_done
//                            I-side burst status, read data and last-word pulse
//   d_req/d_wr/d_addr/d_wdata
//                            D-side request, direction (sampled at grant),
//                            block address and live write data
//   d_grant/d_rvalid/d_rdata/d_done
//                            D-side burst status, read data and last-word pulse
//   widx                     word index within the active burst
//   mem_addr/mem_enable/mem_wr/mem_wdata/mem_rdata
//                            memory port
// -----------------------------------------------------------------------------
module mem_burst_arbiter #(
    parameter int ADDR_WIDTH  = 16,
    parameter int BLOCK_WORDS = 8,
    parameter int IDX_W       = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_grant,
    output logic                  i_rvalid,
    output logic [15:0]           i_rdata,
    output logic                  i_done,
    input  logic                  d_req,
    input  logic                  d_wr,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [15:0]           d_wdata,
    output logic                  d_grant,
    output logic                  d_rvalid,
    output logic [15:0]           d_rdata,
    output logic                  d_done,
    output logic [IDX_W-1:0]      widx,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_enable,
    output logic                  mem_wr,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BURST_I = 2'd1,
        BURST_D = 2'd2
    } state_t;

    // Clears the byte-offset-within-block bits of a requester address.
    localparam logic [ADDR_WIDTH-1:0] BLK_MASK  = ~ADDR_WIDTH'(2 * BLOCK_WORDS - 1);
    localparam logic [IDX_W-1:0]      LAST_WORD = IDX_W'(BLOCK_WORDS - 1);

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   base_reg,  base_next;
    logic                    wr_l_reg,  wr_l_next;
    logic [IDX_W-1:0]        cnt_reg,   cnt_next;
    // 1: D side wins a tie, 0: I side wins a tie
    logic                    pri_reg,   pri_next;

    // Per-side burst signals, index 0 = I side, index 1 = D side
    logic [1:0]  side_sel;
    logic        last_word;
    logic [1:0]  grant_v;
    logic [1:0]  rvalid_v;
    logic [1:0]  done_v;
    logic [15:0] rdata_v [2];

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            base_reg  <= '0;
            wr_l_reg  <= 1'b0;
            cnt_reg   <= '0;
            pri_reg   <= 1'b1;
        end else begin
            state_reg <= state_next;
            base_reg  <= base_next;
            wr_l_reg  <= wr_l_next;
            cnt_reg   <= cnt_next;
            pri_reg   <= pri_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        base_next  = base_reg;
        wr_l_next  = wr_l_reg;
        cnt_next   = cnt_reg;
        pri_next   = pri_reg;
        unique case (state_reg)
            IDLE: begin
                if (d_req && (!i_req || pri_reg)) begin
                    state_next = BURST_D;
                    base_next  = d_addr & BLK_MASK;
                    wr_l_next  = d_wr;
                    cnt_next   = '0;
                end else if (i_req) begin
                    state_next = BURST_I;
                    base_next  = i_addr & BLK_MASK;
                    wr_l_next  = 1'b0;
                    cnt_next   = '0;
                end
            end
            BURST_I, BURST_D: begin
                if (cnt_reg == LAST_WORD) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    // The side just served yields the next tie.
                    pri_next   = (state_reg == BURST_I);
                end else begin
                    cnt_next   = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---------------- output logic ----------------
    // Everything is forced to 0 while rst is high so that a reset landing in
    // the middle of a write burst cannot strobe the memory.
    always_comb begin
        side_sel   = 2'b00;
        last_word  = 1'b0;
        widx       = '0;
        mem_addr   = '0;
        mem_enable = 1'b0;
        mem_wr     = 1'b0;
        mem_wdata  = '0;
        if (!rst && state_reg != IDLE) begin
            side_sel[0] = (state_reg == BURST_I);
            side_sel[1] = (state_reg == BURST_D);
            last_word   = (cnt_reg == LAST_WORD);
            widx        = cnt_reg;
            // base is block-aligned, so the offset never carries out of the block
            mem_addr    = base_reg + ADDR_WIDTH'({cnt_reg, 1'b0});
            mem_enable  = 1'b1;
            mem_wr      = wr_l_reg;
            if (wr_l_reg) begin
                mem_wdata = d_wdata;
            end
        end
    end

    // Fan the shared burst status out to each requester.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_side
            assign grant_v[gi]  = side_sel[gi];
            assign rvalid_v[gi] = side_sel[gi] & ~wr_l_reg;
            assign rdata_v[gi]  = rvalid_v[gi] ? mem_rdata : 16'h0000;
            assign done_v[gi]   = side_sel[gi] & last_word;
        end
    endgenerate

    assign i_grant  = grant_v[0];
    assign i_rvalid = rvalid_v[0];
    assign i_rdata  = rdata_v[0];
    assign i_done   = done_v[0];
    assign d_grant  = grant_v[1];
    assign d_rvalid = rvalid_v[1];
    assign d_rdata  = rdata_v[1];
    assign d_done   = done_v[1];

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_burst_arbiter
//
// Drives directed scenarios into mem_burst_arbiter connected to a behavioural
// memory. A transaction-level model (current owner, word number, block base,
// plus its own copy of memory contents) predicts every output on every falling
// edge. Directed literal checks pin read data, addresses, grant ordering and
// final memory contents.
// -----------------------------------------------------------------------------
module tb_mem_burst_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_grant, i_rvalid, i_done;
    logic [15:0] i_rdata;
    logic        d_req, d_wr;
    logic [15:0] d_addr, d_wdata;
    logic        d_grant, d_rvalid, d_done;
    logic [15:0] d_rdata;
    logic [2:0]  widx;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_enable, mem_wr;

    logic        wmode;   // when set, d_wdata = A000 + widx (combinational)

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_burst_arbiter #(.ADDR_WIDTH(16), .BLOCK_WORDS(8), .IDX_W(3)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_grant(d_grant), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_done(d_done),
        .widx(widx), .mem_addr(mem_addr), .mem_enable(mem_enable), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    assign d_wdata = wmode ? (16'hA000 + {13'd0, widx}) : 16'h0000;

    // Memory driven by the DUT: word[n] = n at start, combinational read.
    logic [15:0] mem [0:32767];
    assign mem_rdata = mem[mem_addr[15:1]];

    initial begin
        for (int n = 0; n < 32768; n++) mem[n] = 16'(n);
        forever begin
            @(posedge clk);
            if (mem_enable && mem_wr) mem[mem_addr[15:1]] <= mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    logic [15:0] ref_mem [0:32767];
    int          m_side;    // 0 none, 1 I, 2 D
    int          m_word;
    logic [15:0] m_base;
    bit          m_wr;
    bit          m_pri_d;

    initial begin
        bit          act;
        logic [15:0] e_addr, e_wdata, e_rdata;
        for (int n = 0; n < 32768; n++) ref_mem[n] = 16'(n);
        m_side  = 0;
        m_word  = 0;
        m_base  = 16'h0000;
        m_wr    = 1'b0;
        m_pri_d = 1'b1;
        forever begin
            @(negedge clk);
            act     = !rst && (m_side != 0);
            e_addr  = act ? (m_base + 16'(2 * m_word)) : 16'h0000;
            e_wdata = (act && m_side == 2 && m_wr) ? (16'hA000 + 16'(m_word)) : 16'h0000;
            e_rdata = ref_mem[e_addr[15:1]];
            chk("i_grant",    32'(i_grant),    32'(act && m_side == 1));
            chk("d_grant",    32'(d_grant),    32'(act && m_side == 2));
            chk("i_rvalid",   32'(i_rvalid),   32'(act && m_side == 1));
            chk("d_rvalid",   32'(d_rvalid),   32'(act && m_side == 2 && !m_wr));
            chk("i_rdata",    32'(i_rdata),    32'((act && m_side == 1) ? e_rdata : 16'h0));
            chk("d_rdata",    32'(d_rdata),    32'((act && m_side == 2 && !m_wr) ? e_rdata : 16'h0));
            chk("i_done",     32'(i_done),     32'(act && m_side == 1 && m_word == 7));
            chk("d_done",     32'(d_done),     32'(act && m_side == 2 && m_word == 7));
            chk("widx",       32'(widx),       act ? 32'(m_word) : 32'h0);
            chk("mem_addr",   32'(mem_addr),   32'(e_addr));
            chk("mem_enable", 32'(mem_enable), 32'(act));
            chk("mem_wr",     32'(mem_wr),     32'(act && m_wr));
            chk("mem_wdata",  32'(mem_wdata),  32'(e_wdata));
            // advance the model to the next cycle
            if (rst) begin
                m_side  = 0;
                m_word  = 0;
                m_pri_d = 1'b1;
            end else if (m_side == 0) begin
                if (d_req && (!i_req || m_pri_d)) begin
                    m_side = 2; m_word = 0; m_base = d_addr & 16'hFFF0; m_wr = d_wr;
                end else if (i_req) begin
                    m_side = 1; m_word = 0; m_base = i_addr & 16'hFFF0; m_wr = 1'b0;
                end
            end else begin
                if (m_side == 2 && m_wr) ref_mem[e_addr[15:1]] = e_wdata;
                if (m_word == 7) begin
                    m_pri_d = (m_side == 1);
                    m_side  = 0;
                    m_word  = 0;
                end else begin
                    m_word++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the done pulse of one side, counting granted words.
    task automatic wait_done(input bit side_d, input int budget, output int words);
        bit seen = 1'b0;
        words = 0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            if (side_d ? d_grant : i_grant) words++;
            if (side_d ? d_done : i_done) seen = 1'b1;
        end
        chk("done_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        int          n;
        bit          seen, dropped;
        logic [15:0] rd [8];
        logic [15:0] ad [8];
        int          code [20];
        logic [15:0] addr_log [20];
        logic        done_log [20];

        rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_wr = 1'b0;
        d_addr = '0; wmode = 1'b0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_enable", 32'(mem_enable), 32'd0);
        chk("rst_grants", 32'({i_grant, d_grant}), 32'd0);

        // ---- read burst ----
        tick();
        rst = 1'b0; i_req = 1'b1; i_addr = 16'h1236;
        n = 0; seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (i_grant && n < 8) begin rd[n] = i_rdata; ad[n] = mem_addr; n++; end
            if (i_done) seen = 1'b1;
        end
        chk("rd_words", 32'(n), 32'd8);
        chk("rd_done", 32'(seen), 32'd1);
        chk("rd_data0", 32'(rd[0]), 32'h0918);
        chk("rd_data7", 32'(rd[7]), 32'h091F);
        chk("rd_addr0", 32'(ad[0]), 32'h1230);
        chk("rd_addr7", 32'(ad[7]), 32'h123E);
        tick();
        i_req = 1'b0;

        // ---- write burst ----
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0040; wmode = 1'b1;
        wait_done(1'b1, 20, n);
        chk("wr_words", 32'(n), 32'd8);
        tick();
        d_req = 1'b0; d_wr = 1'b0; wmode = 1'b0;
        tick();
        for (int k = 0; k < 8; k++) chk("wr_mem", 32'(mem[16'h0020 + 16'(k)]), 32'(16'hA000 + 16'(k)));

        // ---- contention from reset ----
        rst = 1'b1;
        tick();
        rst = 1'b0; i_req = 1'b1; d_req = 1'b1; i_addr = 16'h0300; d_addr = 16'h0200;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            code[k] = d_grant ? 2 : (i_grant ? 1 : 0);
        end
        for (int k = 0; k < 20; k++) begin
            int e;
            e = (k == 0 || k == 9 || k == 18) ? 0 : ((k >= 10 && k <= 17) ? 1 : 2);
            chk("contend_order", 32'(code[k]), 32'(e));
        end
        tick();
        i_req = 1'b0; d_req = 1'b0;
        wait_done(1'b1, 20, n);
        tick();

        // ---- abandoned I request ----
        i_req = 1'b1; i_addr = 16'h2004;
        n = 0; seen = 1'b0; dropped = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (i_grant) n++;
            if (i_done) seen = 1'b1;
            else if (n == 3 && !dropped) begin
                tick();
                i_req = 1'b0;
                dropped = 1'b1;
            end
        end
        chk("abandon_words", 32'(n), 32'd8);
        chk("abandon_done", 32'(seen), 32'd1);
        tick();

        // ---- reset in the middle of a D write ----
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0100; wmode = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (d_grant && widx == 3'd3) seen = 1'b1;
        end
        chk("midrst_reach_w3", 32'(seen), 32'd1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_mem_wr", 32'(mem_wr), 32'd0);
        chk("midrst_grant", 32'(d_grant), 32'd0);
        tick();
        rst = 1'b0; d_req = 1'b0; d_wr = 1'b0; wmode = 1'b0;
        @(negedge clk);
        chk("midrst_idle", 32'(d_grant), 32'd0);
        for (int k = 0; k < 8; k++)
            chk("midrst_mem", 32'(mem[16'h0080 + 16'(k)]),
                (k < 4) ? 32'(16'hA000 + 16'(k)) : 32'(16'h0080 + 16'(k)));

        // ---- back-to-back D reads with address change mid-burst ----
        tick();
        d_req = 1'b1; d_addr = 16'h1236;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            code[k]     = d_grant ? 2 : 0;
            addr_log[k] = mem_addr;
            done_log[k] = d_done;
            if (k == 2) begin
                tick();
                d_addr = 16'h3000;
            end
        end
        chk("b2b_idle0", 32'(code[0]), 32'd0);
        chk("b2b_addr_first", 32'(addr_log[1]), 32'h1230);
        chk("b2b_addr_held", 32'(addr_log[4]), 32'h1236);
        chk("b2b_addr_last", 32'(addr_log[8]), 32'h123E);
        chk("b2b_done", 32'(done_log[8]), 32'd1);
        chk("b2b_gap", 32'(code[9]), 32'd0);
        chk("b2b_regrant", 32'(code[10]), 32'd2);
        chk("b2b_new_base", 32'(addr_log[10]), 32'h3000);
        tick();
        d_req = 1'b0;
        wait_done(1'b1, 20, n);
        tick();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
